// File: rtl/uart_pkg.sv
// Shared UART types and constants: RX/TX state encodings, data width and the
// parity convention used by both directions.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_IDX_W     = $clog2(UART_DATA_BITS);
    // 0 selects even parity: the parity bit makes the total count of ones even
    localparam logic UART_PARITY_ODD = 1'b0;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_states_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_states_t;

    function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] d);
        return (^d) ^ UART_PARITY_ODD;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both stages reset to
// RST_VAL so an idle-high line looks idle straight out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, with a
// single-frame valid/ready output buffer and a sticky overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [UART_IDX_W-1:0] IDX_LAST = UART_IDX_W'(UART_DATA_BITS - 1);

    logic rx_s;

    rx_states_t                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [UART_IDX_W-1:0]     idx_q, idx_d;
    logic                      prev_q, prev_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      par_q, par_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      perr_q, perr_d;
    logic                      ferr_q, ferr_d;
    logic                      ovr_q, ovr_d;

    logic half_hit, bit_hit, deliver, xfer;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign half_hit = (cnt_q == HALF_LAST);
    assign bit_hit  = (cnt_q == BIT_LAST);
    assign xfer     = valid_q & ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:   if (prev_q && !rx_s) state_d = RX_START;
            RX_START:  if (half_hit) state_d = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:   if (bit_hit && idx_q == IDX_LAST) state_d = RX_PARITY;
            RX_PARITY: if (bit_hit) state_d = RX_STOP;
            RX_STOP:   if (bit_hit) state_d = RX_IDLE;
            default:   state_d = RX_IDLE;
        endcase
    end

    // Bit timing and shift register; the counter restarts at each sample point
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        prev_d  = rx_s;
        deliver = 1'b0;
        case (state_q)
            RX_IDLE:  cnt_d = '0;
            RX_START: if (half_hit) cnt_d = '0;
            RX_DATA: begin
                if (bit_hit) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 1'b1;
                end
            end
            RX_PARITY: begin
                if (bit_hit) begin
                    cnt_d = '0;
                    par_d = rx_s;
                end
            end
            RX_STOP: begin
                if (bit_hit) begin
                    cnt_d   = '0;
                    deliver = 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // A delivery is accepted when the buffer is empty or being emptied this edge
    always_comb begin
        valid_d = valid_q & ~xfer;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q & ~xfer;
        if (deliver) begin
            if (!valid_q || xfer) begin
                data_d  = shift_q;
                perr_d  = parity_bit(shift_q) ^ par_q;
                ferr_d  = ~rx_s;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            prev_q  <= 1'b1;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            prev_q  <= prev_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        busy = (state_q != RX_IDLE);
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: good, parity-error and
// framing-error frames, false start, overrun, and reset in mid-frame.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data_out;
    logic       valid, parity_err, frame_err, overrun, busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int         cap_cnt = 0;
    logic [7:0] cap_data = 8'h00;
    logic       cap_pe = 1'b0;
    logic       cap_fe = 1'b0;
    int         valid_hi = 0;
    int         busy_hi = 0;
    int         val_cyc = 0;
    int         start_cyc = 0;
    logic       valid_prev = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .ready      (ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Observe outputs on the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        if (valid) valid_hi++;
        if (busy) busy_hi++;
        if (valid && !valid_prev) val_cyc = cyc;
        valid_prev = valid;
        if (valid && ready) begin
            cap_cnt++;
            cap_data = data_out;
            cap_pe   = parity_err;
            cap_fe   = frame_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        tick();
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        rx = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        total++;
        if ({valid, data_out, parity_err, frame_err, overrun} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 000",
                     {valid, data_out, parity_err, frame_err, overrun});
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        rst = 1'b1;
        repeat (5) tick();
        total++;
        if ({valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL after_reset_idle: got %b want 00", {valid, busy});
        end
    endtask

    task automatic test_good_frame();
        int c0, v0, lat;
        c0 = cap_cnt;
        v0 = valid_hi;
        send_frame(8'hA5, 1'b0, 1'b1);
        lat = val_cyc - start_cyc;
        total++;
        if (cap_cnt != c0 + 1 || valid_hi != v0 + 1) begin
            bad++;
            $display("FAIL a5_one_pulse: got frames=%0d valid_cycles=%0d want 1 and 1",
                     cap_cnt - c0, valid_hi - v0);
        end
        total++;
        if ({cap_data, cap_pe, cap_fe} !== {8'hA5, 2'b00}) begin
            bad++;
            $display("FAIL a5_data: got %h pe=%b fe=%b want a5 pe=0 fe=0", cap_data, cap_pe, cap_fe);
        end
        total++;
        if (lat < 169 || lat > 171) begin
            bad++;
            $display("FAIL a5_latency: got %0d want 169..171", lat);
        end
    endtask

    task automatic test_parity_err();
        int c0;
        c0 = cap_cnt;
        send_frame(8'h01, 1'b0, 1'b1);
        total++;
        if (cap_cnt != c0 + 1 || {cap_data, cap_pe, cap_fe} !== {8'h01, 2'b10}) begin
            bad++;
            $display("FAIL parity_err: got n=%0d %h pe=%b fe=%b want n=1 01 pe=1 fe=0",
                     cap_cnt - c0, cap_data, cap_pe, cap_fe);
        end
    endtask

    task automatic test_frame_err();
        int c0;
        c0 = cap_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        total++;
        if (cap_cnt != c0 + 1 || {cap_data, cap_pe, cap_fe} !== {8'h3C, 2'b01}) begin
            bad++;
            $display("FAIL frame_err: got n=%0d %h pe=%b fe=%b want n=1 3c pe=0 fe=1",
                     cap_cnt - c0, cap_data, cap_pe, cap_fe);
        end
        send_frame(8'h55, 1'b0, 1'b1);
        total++;
        if (cap_cnt != c0 + 2 || {cap_data, cap_pe, cap_fe} !== {8'h55, 2'b00}) begin
            bad++;
            $display("FAIL after_frame_err: got n=%0d %h pe=%b fe=%b want n=2 55 pe=0 fe=0",
                     cap_cnt - c0, cap_data, cap_pe, cap_fe);
        end
    endtask

    task automatic test_false_start();
        int b0, v0;
        tick();
        b0 = busy_hi;
        v0 = valid_hi;
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (30) tick();
        total++;
        if (busy_hi - b0 < 1 || busy_hi - b0 > 10) begin
            bad++;
            $display("FAIL false_start_busy: got %0d busy cycles want 1..10", busy_hi - b0);
        end
        total++;
        if (valid_hi != v0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL false_start_idle: got valid_cycles=%0d busy=%b want 0 and 0",
                     valid_hi - v0, busy);
        end
    endtask

    task automatic test_overrun();
        int c0;
        ready = 1'b0;
        c0 = cap_cnt;
        send_frame(8'h11, 1'b0, 1'b1);
        total++;
        if ({valid, data_out, overrun} !== {1'b1, 8'h11, 1'b0}) begin
            bad++;
            $display("FAIL hold_first: got v=%b %h ovr=%b want v=1 11 ovr=0", valid, data_out, overrun);
        end
        send_frame(8'h22, 1'b0, 1'b1);
        total++;
        if ({valid, data_out, overrun, parity_err, frame_err} !== {1'b1, 8'h11, 3'b100}) begin
            bad++;
            $display("FAIL overrun_set: got v=%b %h ovr=%b pe=%b fe=%b want v=1 11 ovr=1 pe=0 fe=0",
                     valid, data_out, overrun, parity_err, frame_err);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        total++;
        if ({valid, overrun} !== 2'b00) begin
            bad++;
            $display("FAIL overrun_clear: got v=%b ovr=%b want 0 0", valid, overrun);
        end
        total++;
        if (cap_cnt != c0 + 1 || cap_data !== 8'h11) begin
            bad++;
            $display("FAIL overrun_accept: got n=%0d %h want n=1 11", cap_cnt - c0, cap_data);
        end
        ready = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_reset_mid_frame();
        int c0, v0;
        logic [7:0] d;
        d = 8'h77;
        c0 = cap_cnt;
        v0 = valid_hi;
        tick();
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        rx = d[3];
        repeat (CPB / 2) tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_frame_busy: got %b want 1", busy);
        end
        rx = 1'b1;
        rst = 1'b0;
        #1;
        total++;
        if ({busy, valid} !== 2'b00) begin
            bad++;
            $display("FAIL async_reset: got busy=%b valid=%b want 0 0", busy, valid);
        end
        repeat (3) tick();
        rst = 1'b1;
        repeat (20) tick();
        total++;
        if (busy !== 1'b0 || valid_hi != v0) begin
            bad++;
            $display("FAIL aborted_frame: got busy=%b valid_cycles=%0d want 0 and 0", busy, valid_hi - v0);
        end
        send_frame(8'h99, 1'b0, 1'b1);
        total++;
        if (cap_cnt != c0 + 1 || {cap_data, cap_pe, cap_fe, overrun} !== {8'h99, 3'b000}) begin
            bad++;
            $display("FAIL after_abort: got n=%0d %h pe=%b fe=%b ovr=%b want n=1 99 pe=0 fe=0 ovr=0",
                     cap_cnt - c0, cap_data, cap_pe, cap_fe, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_frame_err();
        test_false_start();
        test_overrun();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_BIT, default 16, clk cycles per serial bit; legal values are integers 4 or greater.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- rx  in  1  serial line, asynchronous to clk, idle high
- data_out  out  8  received byte
- valid  out  1  data_out and error flags hold a frame
- ready  in  1  consumer accepts the frame
- parity_err  out  1  even-parity mismatch for the held frame
- frame_err  out  1  stop bit sampled low for the held frame
- overrun  out  1  sticky: at least one frame was dropped
- busy  out  1  a frame is being received (state != IDLE)

Function
REQ-003 Frame format SHALL be: start bit 0, 8 data bits LSB first, 1 even-parity bit (XOR of the 8 data bits), 1 stop bit 1.
REQ-004 rx SHALL pass through a 2-FF synchronizer; all logic SHALL use only the synchronized rx_s.
REQ-005 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, driven by a cycle counter and a 3-bit bit index.
REQ-006 IDLE SHALL move to START on a falling edge of rx_s (previous 1, current 0), and SHALL clear the counter; a line held low SHALL NOT retrigger.
REQ-007 START SHALL sample rx_s when counter == CLKS_PER_BIT/2-1. A sample of 1 SHALL return to IDLE with no output change (false start). A sample of 0 SHALL move to DATA and clear the counter.
REQ-008 DATA, PARITY and STOP SHALL each sample rx_s when counter == CLKS_PER_BIT-1 (mid-bit), then clear the counter.
REQ-009 DATA SHALL shift the sample into bit[index], and SHALL advance to PARITY after index 7 (the index wraps to 0).
REQ-010 PARITY SHALL store the parity sample and move to STOP.
REQ-011 STOP SHALL return to IDLE on the clk edge of the stop sample, and SHALL deliver the frame on that same edge per REQ-012 to REQ-015.
REQ-012 Delivery with valid=0 SHALL load data_out, set parity_err = (^data) ^ parity_sample, set frame_err = ~stop_sample, and set valid=1.
REQ-013 valid, data_out, parity_err and frame_err SHALL stay stable while valid=1 and ready=0. A transfer occurs on any edge with valid && ready, which SHALL clear valid unless REQ-014 applies.
REQ-014 Delivery on the same edge as a transfer SHALL load the new frame and keep valid=1, with no overrun.
REQ-015 Delivery while valid=1 and no transfer SHALL discard the new frame, keep the held one, and set overrun=1.
REQ-016 overrun SHALL clear only on a transfer edge (valid && ready); it SHALL NOT clear on a transfer edge that itself sets overrun.
REQ-017 Frames with parity or framing errors SHALL still be delivered, with their flags set; the receiver SHALL NOT stall.
REQ-018 Latency from the rx falling edge to valid SHALL be 2 + (CLKS_PER_BIT/2) + 10*CLKS_PER_BIT cycles, with ±1 cycle for synchronizer phase.
REQ-019 busy SHALL equal (state != IDLE), decoded combinationally.

Reset
REQ-020 rst low SHALL asynchronously force: state IDLE, counter 0, index 0, synchronizer FFs and previous rx_s to 1, data_out 8'h00, and valid, parity_err, frame_err and overrun all 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no delivery. After release, reception SHALL resume only on a new falling edge.

Structure
REQ-022 Package uart_pkg SHALL hold the RX state enum (RX_STATES), UART_DATA_BITS=8 and the parity convention; the TX state typedef SHALL move there too.
REQ-023 The synchronizer SHALL be the sub-module sync_2ff (clk, rst, d, q, reset value 1); the FSM, datapath and handshake SHALL stay in uart_rx.

Verification (CLKS_PER_BIT=16)
REQ-024 Bench SHALL cover:
- Frame 0xA5, parity 0, stop 1, ready=1 -> one valid pulse, data_out=0xA5, parity_err=0, frame_err=0.
- Frame 0x01, parity 0 -> data_out=0x01, parity_err=1, frame_err=0.
- Frame 0x3C, parity 0, stop 0 -> frame_err=1; a following good frame 0x55 -> data_out=0x55, flags 0.
- rx low for 4 cycles then high -> FSM back to IDLE, valid stays 0, busy high for at most 10 cycles.
- ready=0, frames 0x11 then 0x22 -> data_out=0x11, overrun=1; assert ready one cycle -> valid=0, overrun=0.
- rst pulsed during DATA of frame 0x77, then a full 0x99 frame -> only 0x99 is delivered, all flags 0.
